// File: rtl/data_path_pkg.sv
// data_path_pkg: shared constants for the single-bus datapath.
//   - DATA_WIDTH and the word type
//   - ALU opcode encodings (MUL/DIV only act when MULDIV_EN is defined)
//   - bus source indices, in priority order (lower index wins)
package data_path_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    typedef logic [DATA_WIDTH-1:0] word_t;

    localparam logic [4:0] OpAndAlt = 5'b00001;
    localparam logic [4:0] OpAdd    = 5'b00011;
    localparam logic [4:0] OpSub    = 5'b00100;
    localparam logic [4:0] OpShr    = 5'b00101;
    localparam logic [4:0] OpShra   = 5'b00110;
    localparam logic [4:0] OpShl    = 5'b00111;
    localparam logic [4:0] OpRor    = 5'b01000;
    localparam logic [4:0] OpRol    = 5'b01001;
    localparam logic [4:0] OpAnd    = 5'b01010;
    localparam logic [4:0] OpOr     = 5'b01011;
    localparam logic [4:0] OpMul    = 5'b01111;
    localparam logic [4:0] OpDiv    = 5'b10000;
    localparam logic [4:0] OpNeg    = 5'b10001;
    localparam logic [4:0] OpNot    = 5'b10010;

    // Indices 0..15 are R0..R15.
    localparam int         NumSel    = 24;
    localparam logic [4:0] SelHi     = 5'd16;
    localparam logic [4:0] SelLo     = 5'd17;
    localparam logic [4:0] SelZhi    = 5'd18;
    localparam logic [4:0] SelZlo    = 5'd19;
    localparam logic [4:0] SelPc     = 5'd20;
    localparam logic [4:0] SelMdr    = 5'd21;
    localparam logic [4:0] SelInport = 5'd22;
    localparam logic [4:0] SelC      = 5'd23;

endpackage

// File: rtl/data_path_alu.sv
// data_path_alu: combinational ALU with a 64-bit result {hi, lo}.
//   a_i      : operand A (Y register)
//   b_i      : operand B (bus)
//   opcode_i : operation select
//   inc_pc_i : overrides opcode, result = b_i + 1
//   result_o : {hi, lo}; hi is 0 except for MUL/DIV
// Macro MULDIV_EN enables signed MUL and DIV; otherwise those codes give 0.
module data_path_alu
    import data_path_pkg::*;
(
    input  word_t       a_i,
    input  word_t       b_i,
    input  logic [4:0]  opcode_i,
    input  logic        inc_pc_i,
    output logic [63:0] result_o
);

    logic [4:0] shamt;
    word_t      ror_w;
    word_t      rol_w;

    assign shamt = b_i[4:0];
    // A shift by 32 yields 0, so shamt == 0 degenerates cleanly to A.
    assign ror_w = (a_i >> shamt) | (a_i << (6'd32 - {1'b0, shamt}));
    assign rol_w = (a_i << shamt) | (a_i >> (6'd32 - {1'b0, shamt}));

`ifdef MULDIV_EN
    logic signed [63:0] prod;
    logic signed [31:0] quo;
    logic signed [31:0] rem;

    assign prod = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
    assign quo  = $signed(a_i) / $signed(b_i);
    assign rem  = $signed(a_i) % $signed(b_i);
`endif

    always_comb begin
        result_o = '0;
        if (inc_pc_i) begin
            result_o[31:0] = b_i + 32'd1;
        end else begin
            case (opcode_i)
                OpAdd:           result_o[31:0] = a_i + b_i;
                OpSub:           result_o[31:0] = a_i - b_i;
                OpAnd, OpAndAlt: result_o[31:0] = a_i & b_i;
                OpOr:            result_o[31:0] = a_i | b_i;
                OpShr:           result_o[31:0] = a_i >> shamt;
                OpShra:          result_o[31:0] = $signed(a_i) >>> shamt;
                OpShl:           result_o[31:0] = a_i << shamt;
                OpRor:           result_o[31:0] = ror_w;
                OpRol:           result_o[31:0] = rol_w;
                OpNeg:           result_o[31:0] = 32'd0 - b_i;
                OpNot:           result_o[31:0] = ~b_i;
`ifdef MULDIV_EN
                OpMul:           result_o = prod;
                OpDiv: begin
                    if (b_i != '0) begin
                        result_o = {rem, quo};
                    end
                end
`endif
                default:         result_o = '0;
            endcase
        end
    end

endmodule

// File: rtl/data_path.sv
// data_path: single-bus 32-bit CPU datapath driven cycle-by-cycle by a control unit.
//   clock, clear          : rising-edge clock, synchronous active-low reset
//   *in / IRin .. Inport_in : register load enables (independent)
//   *out / Cout           : bus source selects, fixed priority R0 first, C last
//   IncPC                 : ALU override, Z <= bus + 1
//   Mem_read, MDR_Mem_lines : MDR input mux (1 = memory lines, 0 = bus)
//   Inport_data_in        : data loaded into the in-port register
//   opcode                : ALU operation (A = Y, B = bus)
//   outputs               : MAR, out-port, register taps and current bus value
// Macro MULDIV_EN enables MUL/DIV in the ALU.
module data_path #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  R0in,  R1in,  R2in,  R3in,  R4in,  R5in,  R6in,  R7in,
    input  logic                  R8in,  R9in,  R10in, R11in, R12in, R13in, R14in, R15in,
    input  logic                  IRin,  PCin,  RYin,  RZin,  MARin, MDRin, HIin,  LOin,
    input  logic                  Outport_in, Inport_in, IncPC,
    input  logic                  R0out, R1out, R2out,  R3out,  R4out,  R5out,  R6out,  R7out,
    input  logic                  R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
    input  logic                  HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout,
    input  logic                  Mem_read,
    input  logic [DATA_WIDTH-1:0] MDR_Mem_lines,
    input  logic [DATA_WIDTH-1:0] Inport_data_in,
    input  logic [4:0]            opcode,
    output logic [DATA_WIDTH-1:0] MAR_to_chip,
    output logic [DATA_WIDTH-1:0] Outport_data_out,
    output logic [DATA_WIDTH-1:0] reg1, reg2, reg3, reg4, reg5, reg6, reg7,
    output logic [DATA_WIDTH-1:0] regMDR, PC_VALUE, HI_VALUE, LO_VALUE, IR_VALUE,
    output logic [DATA_WIDTH-1:0] BusMuxOut_out
);
    import data_path_pkg::*;

    logic [DATA_WIDTH-1:0]   gpr_q [16];
    logic [DATA_WIDTH-1:0]   gpr_d [16];
    logic [DATA_WIDTH-1:0]   pc_q, pc_d, ir_q, ir_d, y_q, y_d, mar_q, mar_d, mdr_q, mdr_d;
    logic [DATA_WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, inport_q, inport_d, outport_q, outport_d;
    logic [2*DATA_WIDTH-1:0] z_q, z_d;

    logic [15:0]             gpr_en;
    logic [NumSel-1:0]       sel_vec;
    logic [4:0]              sel_idx;
    logic                    sel_any;
    logic [DATA_WIDTH-1:0]   bus;
    logic [63:0]             alu_result;

    assign gpr_en  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                      R7in,  R6in,  R5in,  R4in,  R3in,  R2in,  R1in, R0in};
    // Bit position equals the Sel* index in the package.
    assign sel_vec = {Cout, Inport_out, MDRout, PCout, Zlo_out, Zhi_out, LOout, HIout,
                      R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                      R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out};

    // Priority encoder: scanning downward leaves the lowest asserted index.
    always_comb begin
        sel_idx = '0;
        sel_any = 1'b0;
        for (int i = NumSel - 1; i >= 0; i--) begin
            if (sel_vec[i]) begin
                sel_idx = 5'(i);
                sel_any = 1'b1;
            end
        end
    end

    always_comb begin
        bus = '0;
        if (sel_any) begin
            if (!sel_idx[4]) begin
                bus = gpr_q[sel_idx[3:0]];
            end else begin
                case (sel_idx)
                    SelHi:     bus = hi_q;
                    SelLo:     bus = lo_q;
                    SelZhi:    bus = z_q[2*DATA_WIDTH-1:DATA_WIDTH];
                    SelZlo:    bus = z_q[DATA_WIDTH-1:0];
                    SelPc:     bus = pc_q;
                    SelMdr:    bus = mdr_q;
                    SelInport: bus = inport_q;
                    SelC:      bus = {{13{ir_q[18]}}, ir_q[18:0]};
                    default:   bus = '0;
                endcase
            end
        end
    end

    data_path_alu u_alu (
        .a_i      (y_q),
        .b_i      (bus),
        .opcode_i (opcode),
        .inc_pc_i (IncPC),
        .result_o (alu_result)
    );

    always_comb begin
        gpr_d = gpr_q;
        for (int i = 0; i < 16; i++) begin
            if (gpr_en[i]) gpr_d[i] = bus;
        end
        pc_d      = PCin       ? bus : pc_q;
        ir_d      = IRin       ? bus : ir_q;
        y_d       = RYin       ? bus : y_q;
        mar_d     = MARin      ? bus : mar_q;
        hi_d      = HIin       ? bus : hi_q;
        lo_d      = LOin       ? bus : lo_q;
        outport_d = Outport_in ? bus : outport_q;
        inport_d  = Inport_in  ? Inport_data_in : inport_q;
        mdr_d     = MDRin      ? (Mem_read ? MDR_Mem_lines : bus) : mdr_q;
        z_d       = RZin       ? alu_result : z_q;
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            for (int i = 0; i < 16; i++) gpr_q[i] <= '0;
            pc_q      <= '0;
            ir_q      <= '0;
            y_q       <= '0;
            z_q       <= '0;
            mar_q     <= '0;
            mdr_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            inport_q  <= '0;
            outport_q <= '0;
        end else begin
            for (int i = 0; i < 16; i++) gpr_q[i] <= gpr_d[i];
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            y_q       <= y_d;
            z_q       <= z_d;
            mar_q     <= mar_d;
            mdr_q     <= mdr_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            inport_q  <= inport_d;
            outport_q <= outport_d;
        end
    end

    assign MAR_to_chip      = mar_q;
    assign Outport_data_out = outport_q;
    assign reg1             = gpr_q[1];
    assign reg2             = gpr_q[2];
    assign reg3             = gpr_q[3];
    assign reg4             = gpr_q[4];
    assign reg5             = gpr_q[5];
    assign reg6             = gpr_q[6];
    assign reg7             = gpr_q[7];
    assign regMDR           = mdr_q;
    assign PC_VALUE         = pc_q;
    assign HI_VALUE         = hi_q;
    assign LO_VALUE         = lo_q;
    assign IR_VALUE         = ir_q;
    assign BusMuxOut_out    = bus;

endmodule

// File: tb/tb_data_path.sv
module tb_data_path;

    // Enable bit positions: 0..15 = R0..R15.
    localparam int E_IR = 16, E_PC = 17, E_Y = 18, E_Z = 19, E_MAR = 20, E_MDR = 21;
    localparam int E_HI = 22, E_LO = 23, E_OUT = 24, E_IN = 25;
    // Select bit positions in priority order: 0..15 = R0..R15.
    localparam int S_HI = 16, S_LO = 17, S_ZHI = 18, S_ZLO = 19, S_PC = 20, S_MDR = 21;
    localparam int S_IN = 22, S_C = 23;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic [25:0] en    = '0;
    logic [23:0] sel   = '0;
    logic        inc   = 1'b0;
    logic        mrd   = 1'b0;
    logic [31:0] mem   = '0;
    logic [31:0] inp   = '0;
    logic [4:0]  op    = '0;

    logic [31:0] mar_o, outp_o, r1, r2, r3, r4, r5, r6, r7;
    logic [31:0] mdr_o, pc_o, hi_o, lo_o, ir_o, bus_o;

    always #5 clock = ~clock;

    data_path dut (
        .clock(clock), .clear(clear),
        .R0in(en[0]), .R1in(en[1]), .R2in(en[2]), .R3in(en[3]),
        .R4in(en[4]), .R5in(en[5]), .R6in(en[6]), .R7in(en[7]),
        .R8in(en[8]), .R9in(en[9]), .R10in(en[10]), .R11in(en[11]),
        .R12in(en[12]), .R13in(en[13]), .R14in(en[14]), .R15in(en[15]),
        .IRin(en[E_IR]), .PCin(en[E_PC]), .RYin(en[E_Y]), .RZin(en[E_Z]),
        .MARin(en[E_MAR]), .MDRin(en[E_MDR]), .HIin(en[E_HI]), .LOin(en[E_LO]),
        .Outport_in(en[E_OUT]), .Inport_in(en[E_IN]), .IncPC(inc),
        .R0out(sel[0]), .R1out(sel[1]), .R2out(sel[2]), .R3out(sel[3]),
        .R4out(sel[4]), .R5out(sel[5]), .R6out(sel[6]), .R7out(sel[7]),
        .R8out(sel[8]), .R9out(sel[9]), .R10out(sel[10]), .R11out(sel[11]),
        .R12out(sel[12]), .R13out(sel[13]), .R14out(sel[14]), .R15out(sel[15]),
        .HIout(sel[S_HI]), .LOout(sel[S_LO]), .Zhi_out(sel[S_ZHI]), .Zlo_out(sel[S_ZLO]),
        .PCout(sel[S_PC]), .MDRout(sel[S_MDR]), .Inport_out(sel[S_IN]), .Cout(sel[S_C]),
        .Mem_read(mrd), .MDR_Mem_lines(mem), .Inport_data_in(inp), .opcode(op),
        .MAR_to_chip(mar_o), .Outport_data_out(outp_o),
        .reg1(r1), .reg2(r2), .reg3(r3), .reg4(r4), .reg5(r5), .reg6(r6), .reg7(r7),
        .regMDR(mdr_o), .PC_VALUE(pc_o), .HI_VALUE(hi_o), .LO_VALUE(lo_o), .IR_VALUE(ir_o),
        .BusMuxOut_out(bus_o)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    logic [31:0] m_r [16];
    logic [31:0] m_pc, m_ir, m_y, m_mar, m_mdr, m_hi, m_lo, m_in, m_out;
    logic [63:0] m_z;
    logic [31:0] last_bus;

    function automatic logic [31:0] m_src(input int i);
        logic [31:0] c;
        c = m_ir[18] ? (32'hFFF8_0000 | m_ir) : (m_ir & 32'h0007_FFFF);
        if (i < 16) return m_r[i];
        case (i)
            S_HI:  return m_hi;
            S_LO:  return m_lo;
            S_ZHI: return m_z[63:32];
            S_ZLO: return m_z[31:0];
            S_PC:  return m_pc;
            S_MDR: return m_mdr;
            S_IN:  return m_in;
            default: return c;
        endcase
    endfunction

    function automatic logic [31:0] m_bus(input logic [23:0] s);
        for (int i = 0; i < 24; i++) if (s[i]) return m_src(i);
        return 32'h0;
    endfunction

    function automatic logic [63:0] m_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [4:0] o, input logic ic);
        int unsigned s;
        logic [63:0] d;
        logic [31:0] lo;
        longint      q, rm;
        s  = b % 32;
        lo = 32'h0;
        if (ic) return {32'h0, b + 32'd1};
        case (o)
            5'b00011: lo = a + b;
            5'b00100: lo = a - b;
            5'b01010, 5'b00001: lo = a & b;
            5'b01011: lo = a | b;
            5'b00101: lo = a >> s;
            5'b00110: lo = (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
            5'b00111: lo = a << s;
            5'b01000: begin d = {a, a} >> s; lo = d[31:0]; end
            5'b01001: begin d = {a, a} << s; lo = d[63:32]; end
            5'b10001: lo = 32'h0 - b;
            5'b10010: lo = ~b;
`ifdef MULDIV_EN
            5'b01111: return longint'($signed(a)) * longint'($signed(b));
            5'b10000: begin
                if (b == 0) return 64'h0;
                q  = longint'($signed(a)) / longint'($signed(b));
                rm = longint'($signed(a)) % longint'($signed(b));
                return {rm[31:0], q[31:0]};
            end
`endif
            default: lo = 32'h0;
        endcase
        return {32'h0, lo};
    endfunction

    task automatic m_clock(input logic clr, input logic [25:0] e, input logic [31:0] b,
                           input logic rd, input logic [31:0] mm, input logic [31:0] ip,
                           input logic [63:0] alu);
        if (!clr) begin
            for (int i = 0; i < 16; i++) m_r[i] = 0;
            {m_pc, m_ir, m_y, m_mar, m_mdr, m_hi, m_lo, m_in, m_out} = '0;
            m_z = 0;
        end else begin
            for (int i = 0; i < 16; i++) if (e[i]) m_r[i] = b;
            if (e[E_IR])  m_ir  = b;
            if (e[E_PC])  m_pc  = b;
            if (e[E_Y])   m_y   = b;
            if (e[E_Z])   m_z   = alu;
            if (e[E_MAR]) m_mar = b;
            if (e[E_MDR]) m_mdr = rd ? mm : b;
            if (e[E_HI])  m_hi  = b;
            if (e[E_LO])  m_lo  = b;
            if (e[E_OUT]) m_out = b;
            if (e[E_IN])  m_in  = ip;
        end
    endtask

    // One clock: drive after the falling edge, check the bus before the rising edge,
    // then check every tap just after it.
    task automatic step(input logic clr, input logic [25:0] e, input logic [23:0] s,
                        input logic ic, input logic rd, input logic [31:0] mm,
                        input logic [31:0] ip, input logic [4:0] o);
        logic [31:0] b;
        logic [63:0] alu;
        @(negedge clock);
        clear = clr; en = e; sel = s; inc = ic; mrd = rd; mem = mm; inp = ip; op = o;
        #1;
        b        = m_bus(s);
        alu      = m_alu(m_y, b, o, ic);
        last_bus = bus_o;
        chk("bus", bus_o, b);
        @(posedge clock);
        #1;
        m_clock(clr, e, b, rd, mm, ip, alu);
        chk("reg1", r1, m_r[1]);  chk("reg2", r2, m_r[2]);  chk("reg3", r3, m_r[3]);
        chk("reg4", r4, m_r[4]);  chk("reg5", r5, m_r[5]);  chk("reg6", r6, m_r[6]);
        chk("reg7", r7, m_r[7]);  chk("regMDR", mdr_o, m_mdr);
        chk("PC", pc_o, m_pc);    chk("HI", hi_o, m_hi);    chk("LO", lo_o, m_lo);
        chk("IR", ir_o, m_ir);    chk("MAR", mar_o, m_mar); chk("Outport", outp_o, m_out);
    endtask

    // ---------------- directed vector table ----------------
    typedef enum {TNone, TBus, TReg1, TReg2, TReg3, TMdr, TPc, TIr, TMar} tap_e;
    typedef struct {
        logic        clr;
        logic [25:0] en;
        logic [23:0] sel;
        logic        inc;
        logic        mrd;
        logic [31:0] mem;
        logic [4:0]  op;
        tap_e        tap;
        logic [31:0] exp;
        string       name;
    } vec_t;
    vec_t tbl[$];

    function automatic logic [25:0] eb(input int i);
        return 26'd1 << i;
    endfunction
    function automatic logic [23:0] sb(input int i);
        return 24'd1 << i;
    endfunction

    task automatic add(input string nm, input logic c, input logic [25:0] e,
                       input logic [23:0] s, input logic ic, input logic rd,
                       input logic [31:0] mm, input logic [4:0] o, input tap_e t,
                       input logic [31:0] x);
        vec_t v;
        v.name = nm; v.clr = c; v.en = e; v.sel = s; v.inc = ic; v.mrd = rd;
        v.mem = mm; v.op = o; v.tap = t; v.exp = x;
        tbl.push_back(v);
    endtask

    function automatic logic [31:0] tap_val(input tap_e t);
        case (t)
            TBus:  return last_bus;
            TReg1: return r1;
            TReg2: return r2;
            TReg3: return r3;
            TMdr:  return mdr_o;
            TPc:   return pc_o;
            TIr:   return ir_o;
            default: return mar_o;
        endcase
    endfunction

    initial begin
        for (int i = 0; i < 16; i++) m_r[i] = 0;
        {m_pc, m_ir, m_y, m_mar, m_mdr, m_hi, m_lo, m_in, m_out} = '0;
        m_z = 0;
        last_bus = 0;

        add("reset_reg1", 0, 0, 0, 0, 0, 0, 0, TReg1, 32'h0);
        add("idle_bus0",  1, 0, 0, 0, 0, 0, 0, TBus,  32'h0);
        add("reset_pc",   1, 0, 0, 0, 0, 0, 0, TPc,   32'h0);
        add("mdr_mem",    1, eb(E_MDR), 0, 0, 1, 32'hFFFA_0000, 0, TMdr, 32'hFFFA_0000);
        add("r2_pc_load", 1, eb(2) | eb(E_PC), sb(S_MDR), 0, 0, 0, 0, TReg2, 32'hFFFA_0000);
        add("pc_load",    1, 0, 0, 0, 0, 0, 0, TPc, 32'hFFFA_0000);
        add("mdr_4",      1, eb(E_MDR), 0, 0, 1, 32'h4, 0, TMdr, 32'h4);
        add("r3_load",    1, eb(3), sb(S_MDR), 0, 0, 0, 0, TReg3, 32'h4);
        add("mdr_18",     1, eb(E_MDR), 0, 0, 1, 32'h18, 0, TMdr, 32'h18);
        add("r1_load",    1, eb(1), sb(S_MDR), 0, 0, 0, 0, TReg1, 32'h18);
        add("fetch_mar",  1, eb(E_MAR) | eb(E_Z), sb(S_PC), 1, 0, 0, 0, TMar, 32'hFFFA_0000);
        add("fetch_zlo",  1, eb(E_PC) | eb(E_MDR), sb(S_ZLO), 0, 1, 32'h2891_8000, 0,
            TBus, 32'hFFFA_0001);
        add("fetch_pc",   1, 0, 0, 0, 0, 0, 0, TPc, 32'hFFFA_0001);
        add("fetch_ir",   1, eb(E_IR), sb(S_MDR), 0, 0, 0, 0, TIr, 32'h2891_8000);
        add("c_sext",     1, 0, sb(S_C), 0, 0, 0, 0, TBus, 32'h0001_8000);
        add("shr_y",      1, eb(E_Y), sb(2), 0, 0, 0, 0, TNone, 0);
        add("shr_z",      1, eb(E_Z), sb(3), 0, 0, 0, 5'b00101, TNone, 0);
        add("shr_res",    1, eb(1), sb(S_ZLO), 0, 0, 0, 0, TReg1, 32'h0FFF_A000);
        add("shra_y",     1, eb(E_Y), sb(2), 0, 0, 0, 0, TNone, 0);
        add("shra_z",     1, eb(E_Z), sb(3), 0, 0, 0, 5'b00110, TNone, 0);
        add("shra_res",   1, eb(1), sb(S_ZLO), 0, 0, 0, 0, TReg1, 32'hFFFF_A000);
        add("shl_y",      1, eb(E_Y), sb(2), 0, 0, 0, 0, TNone, 0);
        add("shl_z",      1, eb(E_Z), sb(3), 0, 0, 0, 5'b00111, TNone, 0);
        add("shl_res",    1, eb(1), sb(S_ZLO), 0, 0, 0, 0, TReg1, 32'hFFA0_0000);
        add("shl_zhi",    1, 0, sb(S_ZHI), 0, 0, 0, 0, TBus, 32'h0);
        add("prio_r2_r3", 1, 0, sb(2) | sb(3), 0, 0, 0, 0, TBus, 32'hFFFA_0000);
        // Load and read R2 in the same cycle: bus sees the old value.
        add("rw_same",    1, eb(2), sb(2) | sb(S_PC), 0, 0, 0, 0, TBus, 32'hFFFA_0000);
        add("rw_after",   1, 0, 0, 0, 0, 0, 0, TReg2, 32'hFFFA_0000);
        // Reset wins over a simultaneous load.
        add("rst_prio",   0, eb(1), sb(S_PC), 0, 0, 0, 0, TReg1, 32'h0);

        for (int k = 0; k < tbl.size(); k++) begin
            step(tbl[k].clr, tbl[k].en, tbl[k].sel, tbl[k].inc, tbl[k].mrd,
                 tbl[k].mem, 32'h0, tbl[k].op);
            if (tbl[k].tap != TNone) chk(tbl[k].name, tap_val(tbl[k].tap), tbl[k].exp);
        end

        // ---------------- randomized run against the model ----------------
        for (int n = 0; n < 800; n++) begin
            logic [23:0] s;
            int          k;
            s = '0;
            k = $urandom_range(0, 2);
            for (int j = 0; j < k; j++) s[$urandom_range(0, 23)] = 1'b1;
            step($urandom_range(0, 49) != 0, 26'($urandom & $urandom), s,
                 $urandom_range(0, 7) == 0, 1'($urandom), $urandom, $urandom,
                 5'($urandom_range(0, 31)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/data_path.md
Name: data_path

Overview:
- Single-bus 32-bit CPU datapath: sixteen general registers R0–R15, PC, IR, Y, 64-bit Z, HI, LO, MAR, MDR, in/out ports, bus multiplexer with one-hot select encoder, combinational ALU.
- Driven cycle-by-cycle by an external control unit or bench.
- Internal register values are exported for observation.

Parameters:
- DATA_WIDTH, 32, datapath word width; only 32 is supported.

Ports:
- clock  input  1  rising-edge clock
- clear  input  1  synchronous active-low reset
- R0in..R15in, IRin, PCin, RYin, RZin, MARin, MDRin, HIin, LOin, Outport_in, Inport_in  input  1 each  register load enables
- IncPC  input  1  ALU override: Z <= bus + 1
- R0out..R15out, HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout  input  1 each  bus source selects
- Mem_read  input  1  MDR input mux: 1 = memory lines, 0 = bus
- MDR_Mem_lines  input  32  memory read data
- Inport_data_in  input  32  external input port data
- opcode  input  5  ALU operation
- MAR_to_chip  output  32  MAR contents
- Outport_data_out  output  32  outport register
- reg1..reg7, regMDR, PC_VALUE, HI_VALUE, LO_VALUE, IR_VALUE  output  32 each  register observation taps
- BusMuxOut_out  output  32  current bus value

Behaviour:
- Reset: all registers, including Z, clear to 0 on a rising edge with clear=0. Outputs then read 0.
- Loads: on each rising edge with clear=1, every register whose enable is high loads. Enables are independent.
  - MDR loads MDR_Mem_lines if Mem_read=1, else the bus.
  - Inport loads Inport_data_in.
  - Z loads the 64-bit ALU result when RZin=1.
- Bus is combinational with fixed priority: R0..R15, HI, LO, Zhi, Zlo, PC, MDR, Inport, C.
  - Lowest-listed asserted select wins.
  - No select asserted: bus = 0.
  - C = sign-extended IR[18:0].
- ALU: A = Y, B = bus. Result is 64-bit; unless stated, hi = 0.
  - 00011 ADD; 00100 SUB (A−B); 01010 AND; 00001 AND (alias); 01011 OR.
  - 00101 SHR, 00110 SHRA, 00111 SHL: A shifted by B[4:0].
  - 01000 ROR, 01001 ROL: A rotated by B[4:0].
  - 10001 NEG (−B); 10010 NOT (~B).
  - Any other code: result 0.
- IncPC=1 overrides opcode: result lo = bus + 1, hi = 0.
- Arithmetic wraps modulo 2^32. Shift amounts ≥32 are not possible (5-bit).
- Simultaneous load and read of the same register in one cycle: the bus sees the old value; the new value is visible next cycle.
- Reset has priority over all loads.

Optional Feature:
- MULDIV_EN defined:
  - 01111 MUL: signed A×B, 64-bit into Z {hi, lo}.
  - 10000 DIV: Z lo = signed quotient A/B, Z hi = remainder. B = 0 gives Z = 0.
- MULDIV_EN undefined: both codes give result 0.

Decomposition:
- Shared package data_path_pkg: opcode localparams, DATA_WIDTH constant, bus-select index constants.
- One natural sub-module: data_path_alu, a combinational 64-bit-result ALU. Registers, encoder and mux stay inline.

Test Plan:
- Reset: clear=0 for one edge → all observation taps 0, BusMuxOut_out = 0.
- Register load sequence:
  - Mem_read=1, MDRin=1 with 0xFFFA0000 → regMDR = 0xFFFA0000.
  - Then MDRout, R2in, PCin → reg2 = PC_VALUE = 0xFFFA0000.
  - Load R3 = 0x4 and R1 = 0x18 the same way.
- Fetch:
  - PCout + IncPC + MARin + RZin → MAR_to_chip = 0xFFFA0000; Z lo = 0xFFFA0001.
  - Zlo_out + PCin, with memory word 0x28918000 read into MDR → PC_VALUE = 0xFFFA0001.
  - MDRout + IRin → IR_VALUE = 0x28918000.
- SHR: R2out + RYin, then R3out + opcode 00101 + RZin, then Zlo_out + R1in → reg1 = 0x0FFFA000.
- SHRA with the same sequence, opcode 00110 → reg1 = 0xFFFFA000.
- SHL with the same sequence, opcode 00111 → reg1 = 0xFFA00000.
- Bus priority: R2out and R3out asserted together → BusMuxOut_out = R2 value.
